pop_dist_sched: RTL and testbench

POP_DIST_SCHED -- requirements
Module: pop_dist_sched

---
 rtl/gbr_pkg.sv | 17 +
 rtl/best_tracker.sv | 27 ++
 rtl/pop_dist_sched.sv | 119 +++++++++++
 tb/tb_pop_dist_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbr_pkg.sv
// Shared defaults and FSM encoding for the population distance scheduler.
package gbr_pkg;

  localparam int N_IND_DEF   = 25;
  localparam int IND_W_DEF   = 75;
  localparam int DIST_W_DEF  = 12;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STORE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/best_tracker.sv
// Running minimum over the stored distances; ties keep the earliest index.
module best_tracker
  import gbr_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              update,
  input  logic [4:0]        cand_idx,
  input  logic [DIST_W-1:0] cand_dist,
  output logic [4:0]        best_idx,
  output logic [DIST_W-1:0] best_dist
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_idx  <= '0;
      best_dist <= '1;
    end else if (update && (cand_dist < best_dist)) begin
      best_idx  <= cand_idx;
      best_dist <= cand_dist;
    end
  end

endmodule

// File: rtl/pop_dist_sched.sv
// Time-shares one external distance unit across a latched population and
// records every distance plus the best (smallest) one.
module pop_dist_sched
  import gbr_pkg::*;
#(
  parameter int N_IND   = N_IND_DEF,
  parameter int IND_W   = IND_W_DEF,
  parameter int DIST_W  = DIST_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_IND*IND_W-1:0]    pop,
  output logic                      cd_start,
  output logic [IND_W-1:0]          cd_in,
  input  logic                      cd_done,
  input  logic [DIST_W-1:0]         cd_distance,
  output logic [N_IND*DIST_W-1:0]   distances,
  output logic [4:0]                best_idx,
  output logic [DIST_W-1:0]         best_dist,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]        IDX_LAST = 5'(N_IND - 1);

  state_t                   state, state_nxt;
  logic [N_IND*IND_W-1:0]   pop_q;
  logic [4:0]               idx;
  logic [CNT_W-1:0]         wcnt;
  logic [DIST_W-1:0]        cap_dist;
  logic                     accept, got_result, timed_out;

  assign accept     = (state == S_IDLE) && start;
  // wcnt==0 is the guard cycle: a done level left over from the last launch is ignored.
  assign got_result = (state == S_WAIT) && (wcnt != '0) && cd_done;
  assign timed_out  = (state == S_WAIT) && !got_result && (wcnt == CNT_LAST);

  assign cd_in = pop_q[int'(idx)*IND_W +: IND_W];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cd_start  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        cd_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:   if (got_result || timed_out) state_nxt = S_STORE;
      S_STORE:  state_nxt = (idx == IDX_LAST) ? S_FINISH : S_LAUNCH;
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the wide population copy carries no reset; it is always reloaded
  // on an accepted start before anything reads it.
  always_ff @(posedge clk) begin
    if (accept) pop_q <= pop;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      wcnt      <= '0;
      cap_dist  <= '0;
      distances <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        idx <= '0;
        err <= 1'b0;
      end
      if (state == S_WAIT) begin
        wcnt <= wcnt + 1'b1;
        if (got_result) begin
          cap_dist <= cd_distance;
        end else if (timed_out) begin
          cap_dist <= '1;
          err      <= 1'b1;
        end
      end else begin
        wcnt <= '0;
      end
      if (state == S_STORE) begin
        distances[int'(idx)*DIST_W +: DIST_W] <= cap_dist;
        if (idx != IDX_LAST) idx <= idx + 5'd1;
      end
    end
  end

  best_tracker #(.DIST_W(DIST_W)) u_best (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .update    (state == S_STORE),
    .cand_idx  (idx),
    .cand_dist (cap_dist),
    .best_idx  (best_idx),
    .best_dist (best_dist)
  );

endmodule

// File: tb/tb_pop_dist_sched.sv
// Directed bench for pop_dist_sched with a 3-cycle behavioural distance unit.
module tb_pop_dist_sched;

  localparam int N  = 25;
  localparam int IW = 75;
  localparam int DW = 12;
  localparam int TO = 16;

  logic               clk;
  logic               rst;
  logic               start;
  logic [N*IW-1:0]    pop;
  logic               cd_start;
  logic [IW-1:0]      cd_in;
  logic               cd_done;
  logic [DW-1:0]      cd_distance;
  logic [N*DW-1:0]    distances;
  logic [4:0]         best_idx;
  logic [DW-1:0]      best_dist;
  logic               busy, done, err;

  int n_checks = 0;
  int n_err    = 0;

  int model_dist [N];
  int exp_dist   [N];
  int drop_idx;
  logic stale_mode;

  logic [N*IW-1:0] pop_a, pop_b;
  int d, pulses, hit, inj;

  pop_dist_sched #(.N_IND(N), .IND_W(IW), .DIST_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pop         (pop),
    .cd_start    (cd_start),
    .cd_in       (cd_in),
    .cd_done     (cd_done),
    .cd_distance (cd_distance),
    .distances   (distances),
    .best_idx    (best_idx),
    .best_dist   (best_dist),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distance unit model: result level rises 3 cycles after the launch pulse.
  // Stale mode keeps the previous done/distance through the first wait cycle.
  logic [1:0] lat;
  logic [4:0] cur;
  logic       cur_alt;
  always @(posedge clk) begin
    if (rst) begin
      cd_done     <= 1'b0;
      cd_distance <= '0;
      lat         <= '0;
    end else if (cd_start) begin
      cur     <= cd_in[4:0];
      cur_alt <= cd_in[IW-1];
      lat     <= 2'd3;
      if (!stale_mode) cd_done <= 1'b0;
    end else if (lat != 2'd0) begin
      lat <= lat - 2'd1;
      if (lat == 2'd3 && stale_mode) cd_done <= 1'b0;
      if (lat == 2'd2 && int'(cur) != drop_idx) begin
        cd_done     <= 1'b1;
        cd_distance <= DW'(model_dist[cur] + (cur_alt ? 1000 : 0));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*IW-1:0] build_pop(input logic alt);
    logic [N*IW-1:0] p;
    logic [IW-1:0]   ind;
    p = '0;
    for (int i = 0; i < N; i++) begin
      ind          = '0;
      ind[4:0]     = 5'(i);
      ind[39:8]    = 32'(i) * 32'h9e37_79b1;
      ind[IW-1]    = alt;
      p[i*IW +: IW] = ind;
    end
    return p;
  endfunction

  // Starts a run and samples on falling edges; cycle 1 is the first cycle
  // after the accepting edge. Stops three cycles after the first done.
  task automatic run_pop(input logic [N*IW-1:0] p, output int done_cyc, output int n_done);
    done_cyc = 0;
    n_done   = 0;
    @(negedge clk);
    pop   = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) check("busy_after_start", busy, 1'b1);
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (done_cyc != 0 && c >= done_cyc + 3) break;
    end
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_slot%0d", tag, i), 32'(distances[i*DW +: DW]), 32'(exp_dist[i]));
  endtask

  task automatic set_dist_linear(input int base, input int step);
    for (int i = 0; i < N; i++) begin
      model_dist[i] = base + step * i;
      exp_dist[i]   = base + step * i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pop        = '0;
    stale_mode = 1'b0;
    drop_idx   = -1;
    set_dist_linear(0, 0);
    pop_a = build_pop(1'b0);
    pop_b = build_pop(1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cd_start", cd_start, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_distances", 32'(|distances), 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_dist", best_dist, 12'hfff);
    rst = 1'b0;

    // Ascending distances: full run latency, every slot, best at index 0
    set_dist_linear(100, 1);
    run_pop(pop_a, d, pulses);
    check("t1_done_cycle", d, N*5 + 1);
    check("t1_done_pulses", pulses, 1);
    check("t1_busy_after", busy, 1'b0);
    check_slots("t1");
    check("t1_best_idx", best_idx, 0);
    check("t1_best_dist", best_dist, 100);
    check("t1_err", err, 1'b0);

    // Tie on the minimum keeps the lower index
    for (int i = 0; i < N; i++) begin model_dist[i] = 500; exp_dist[i] = 500; end
    model_dist[7] = 42;  exp_dist[7] = 42;
    model_dist[19] = 42; exp_dist[19] = 42;
    run_pop(pop_a, d, pulses);
    check_slots("t2");
    check("t2_best_idx", best_idx, 7);
    check("t2_best_dist", best_dist, 42);

    // Unit never answers for index 3: timeout substitutes all-ones
    set_dist_linear(100, 1);
    exp_dist[3] = 12'hfff;
    drop_idx    = 3;
    run_pop(pop_a, d, pulses);
    check("t3_done_cycle", d, N*5 + 1 + (TO - 3));
    check("t3_done_pulses", pulses, 1);
    check_slots("t3");
    check("t3_err", err, 1'b1);
    check("t3_best_idx", best_idx, 0);
    check("t3_best_dist", best_dist, 100);
    drop_idx = -1;
    exp_dist[3] = 103;

    // Mid-run start with another population, and start during FINISH, both ignored
    @(negedge clk);
    pop   = pop_a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d   = 0;
    inj = 0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) begin
        @(negedge clk);
        start = 1'b0;
      end
      if (d != 0 && c == d + 1) begin
        check("t4_finish_start_ignored", busy, 1'b0);
        break;
      end
      if (cd_start && cd_in[4:0] == 5'd10 && inj == 0) begin
        pop   = pop_b;
        start = 1'b1;
        inj   = 1;
      end
      if (done && d == 0) begin
        d     = c;
        start = 1'b1;
      end
    end
    start = 1'b0;
    check("t4_done_cycle", d, N*5 + 1);
    check_slots("t4");
    check("t4_err_cleared", err, 1'b0);
    check("t4_best_dist", best_dist, 100);

    // Reset during the wait of index 12 aborts the run without done
    @(negedge clk);
    pop   = pop_a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk);
      if (cd_start && cd_in[4:0] == 5'd12) begin
        hit = c;
        break;
      end
    end
    check("t5_launch12_cycle", hit, 12*5 + 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_cd_start", cd_start, 1'b0);
    check("t5_rst_err", err, 1'b0);
    check("t5_rst_distances", 32'(|distances), 0);
    check("t5_rst_best_idx", best_idx, 0);
    check("t5_rst_best_dist", best_dist, 12'hfff);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("t5_no_done_after_abort", pulses, 0);
    set_dist_linear(300, -1);
    run_pop(pop_a, d, pulses);
    check("t5_rerun_done_cycle", d, N*5 + 1);
    check_slots("t5");
    check("t5_best_idx", best_idx, 24);
    check("t5_best_dist", best_dist, 276);

    // Stale done level from the previous evaluation must not be captured
    stale_mode = 1'b1;
    set_dist_linear(900, -5);
    run_pop(pop_a, d, pulses);
    check("t6_done_cycle", d, N*5 + 1);
    check("t6_done_pulses", pulses, 1);
    check_slots("t6");
    check("t6_best_idx", best_idx, 24);
    check("t6_best_dist", best_dist, 780);
    check("t6_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
